// File: rtl/axi_w_router_pkg.sv
// axi_w_router_pkg
//   Shared types and width helpers for the W-channel destination router.
//   - w_router_state_e : FSM states of axi_w_dest_router (ROUTE, SINK, DONE)
//   - fifo_ptr_t       : read/write pointer width for a given FIFO depth
//   - fifo_cnt_t       : occupancy counter width for a given FIFO depth
package axi_w_router_pkg;

  typedef enum logic [1:0] {
    ROUTE = 2'd0,
    SINK  = 2'd1,
    DONE  = 2'd2
  } w_router_state_e;

  function automatic int fifo_ptr_t(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that "full" (count == depth) is representable.
  function automatic int fifo_cnt_t(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi_dest_fifo.sv
// axi_dest_fifo
//   Circular FIFO of one-hot destinations. Pointers wrap naturally, so
//   DEPTH must be a power of two (>= 2). A push while full is dropped and a
//   pop while empty is ignored.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : write request and one-hot destination
//   pop           : remove head entry
//   head          : oldest entry (only meaningful when !empty)
//   full, empty   : occupancy flags
//   count         : number of stored entries
module axi_dest_fifo
  import axi_w_router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [fifo_cnt_t(DEPTH)-1:0] count
);

  localparam int PTR_W = fifo_ptr_t(DEPTH);
  localparam int CNT_W = fifo_cnt_t(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, because the counter gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_w_dest_router.sv
// axi_w_dest_router
//   W-channel router behind the AW decoder. Queues one-hot destinations of
//   accepted writes and steers W beats to the head port until wlast. For
//   writes that missed every region it absorbs the burst (SINK) and pulses
//   wdata_error_completed_o once the last beat is gone (DONE).
//   Optional feature macro: AXI_W_DEST_FALLTHROUGH_EN -- when the FIFO is
//   empty in ROUTE, a pushed DEST_i steers W beats in the same cycle.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   push_DEST_i, DEST_i      : destination push from the AW decoder
//   grant_FIFO_DEST_o        : FIFO can accept a push
//   wvalid_i, wlast_i        : upstream W valid / last
//   wready_o                 : upstream W ready
//   wvalid_o, wready_i       : per-initiator-port W valid / ready
//   handle_error_i           : absorb the burst of the errored write
//   wdata_error_completed_o  : one-cycle pulse, errored burst absorbed
module axi_w_dest_router
  import axi_w_router_pkg::*;
#(
  parameter int N_INIT_PORT = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_DEST_i,
  input  logic [N_INIT_PORT-1:0] DEST_i,
  output logic                   grant_FIFO_DEST_o,
  input  logic                   wvalid_i,
  input  logic                   wlast_i,
  output logic                   wready_o,
  output logic [N_INIT_PORT-1:0] wvalid_o,
  input  logic [N_INIT_PORT-1:0] wready_i,
  input  logic                   handle_error_i,
  output logic                   wdata_error_completed_o
);

  localparam int CNT_W = fifo_cnt_t(FIFO_DEPTH);

  w_router_state_e        state;
  logic [N_INIT_PORT-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   route_en;
  logic [N_INIT_PORT-1:0] route_dest;
  logic                   last_hs;
`ifdef AXI_W_DEST_FALLTHROUGH_EN
  logic                   ft_take;
`endif

  axi_dest_fifo #(
    .WIDTH (N_INIT_PORT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (DEST_i),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign grant_FIFO_DEST_o = (fifo_count != CNT_W'(FIFO_DEPTH));

  // Select which destination (if any) the W beat is steered to this cycle.
  // NOTE: every signal gets a default at the top of the always_comb, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    route_en   = 1'b0;
    route_dest = fifo_head;
`ifdef AXI_W_DEST_FALLTHROUGH_EN
    ft_take    = 1'b0;
`endif
    if (state == ROUTE && !fifo_empty) begin
      route_en = 1'b1;
    end
`ifdef AXI_W_DEST_FALLTHROUGH_EN
    // Empty FIFO implies grant, so the raw push request is enough here.
    else if (state == ROUTE && push_DEST_i) begin
      route_en   = 1'b1;
      route_dest = DEST_i;
      ft_take    = 1'b1;
    end
`endif
  end

  always_comb begin
    wvalid_o = '0;
    wready_o = 1'b0;
    case (state)
      ROUTE: begin
        if (route_en) begin
          wvalid_o = {N_INIT_PORT{wvalid_i}} & route_dest;
          wready_o = |(wready_i & route_dest);
        end
      end
      SINK:    wready_o = 1'b1;
      default: ;
    endcase
  end

  assign last_hs  = wvalid_i & wready_o & wlast_i;
  assign fifo_pop = (state == ROUTE) & ~fifo_empty & last_hs;
`ifdef AXI_W_DEST_FALLTHROUGH_EN
  // A burst that completes entirely in its push cycle never needs storing.
  assign fifo_push = push_DEST_i & ~fifo_full & ~(ft_take & last_hs);
`else
  assign fifo_push = push_DEST_i & ~fifo_full;
`endif

  // Completion flag is registered: it is high exactly while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= ROUTE;
      wdata_error_completed_o <= 1'b0;
    end else begin
      wdata_error_completed_o <= 1'b0;
      case (state)
        ROUTE: if (handle_error_i && fifo_empty) state <= SINK;
        SINK: begin
          if (wvalid_i && wlast_i) begin
            state                   <= DONE;
            wdata_error_completed_o <= 1'b1;
          end
        end
        DONE:    state <= ROUTE;
        default: state <= ROUTE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_w_dest_router.sv
// tb_axi_w_dest_router
//   Table-driven directed vectors plus randomized traffic for
//   axi_w_dest_router. Every cycle is also compared against a queue-based
//   reference model of the router's rules.
module tb_axi_w_dest_router;

  localparam int N = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         push_DEST_i;
  logic [N-1:0] DEST_i;
  logic         grant_FIFO_DEST_o;
  logic         wvalid_i;
  logic         wlast_i;
  logic         wready_o;
  logic [N-1:0] wvalid_o;
  logic [N-1:0] wready_i;
  logic         handle_error_i;
  logic         wdata_error_completed_o;

  always #5 clk = ~clk;

  axi_w_dest_router #(
    .N_INIT_PORT (N),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .push_DEST_i             (push_DEST_i),
    .DEST_i                  (DEST_i),
    .grant_FIFO_DEST_o       (grant_FIFO_DEST_o),
    .wvalid_i                (wvalid_i),
    .wlast_i                 (wlast_i),
    .wready_o                (wready_o),
    .wvalid_o                (wvalid_o),
    .wready_i                (wready_i),
    .handle_error_i          (handle_error_i),
    .wdata_error_completed_o (wdata_error_completed_o)
  );

  typedef struct {
    logic       rst;
    logic       push;
    logic [7:0] dest;
    logic       wv;
    logic       wl;
    logic [7:0] wr;
    logic       herr;
    logic [7:0] e_wv;
    logic       e_wr;
    logic       e_gnt;
    logic       e_cmpl;
  } vec_t;

  function automatic vec_t v(input logic r, input logic p, input logic [7:0] d,
                             input logic wv, input logic wl, input logic [7:0] wr,
                             input logic he, input logic [7:0] ewv, input logic ewr,
                             input logic eg, input logic ec);
    vec_t t;
    t.rst = r; t.push = p; t.dest = d; t.wv = wv; t.wl = wl; t.wr = wr;
    t.herr = he; t.e_wv = ewv; t.e_wr = ewr; t.e_gnt = eg; t.e_cmpl = ec;
    return t;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of destination port numbers plus a phase
  // (0 = routing, 1 = absorbing an errored burst, 2 = completion cycle).
  int q[$];
  int phase    = 0;
  bit model_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [7:0] d);
    for (int i = 0; i < N; i++) if (d[i]) return i;
    return 0;
  endfunction

  task automatic step(input vec_t t, input bit use_exp, input string tag);
    logic [7:0] m_wv;
    logic       m_wr, m_gnt, m_cmpl, hs, ft;
    int         port, sz;
    @(negedge clk);
    rst = t.rst; push_DEST_i = t.push; DEST_i = t.dest; wvalid_i = t.wv;
    wlast_i = t.wl; wready_i = t.wr; handle_error_i = t.herr;
    #1;
    sz = q.size(); m_wv = '0; m_wr = 1'b0; ft = 1'b0; port = -1;
    if (phase == 0) begin
      if (sz > 0) port = q[0];
`ifdef AXI_W_DEST_FALLTHROUGH_EN
      else if (t.push) begin
        port = idx_of(t.dest);
        ft   = 1'b1;
      end
`endif
      if (port >= 0) begin
        m_wv = t.wv ? (8'h01 << port) : 8'h00;
        m_wr = t.wr[port];
      end
    end else if (phase == 1) begin
      m_wr = 1'b1;
    end
    m_gnt  = (sz < D);
    m_cmpl = (phase == 2);
    if (model_ok) begin
      check({tag, " model wvalid_o"}, 32'(wvalid_o), 32'(m_wv));
      check({tag, " model wready_o"}, 32'(wready_o), 32'(m_wr));
      check({tag, " model grant"}, 32'(grant_FIFO_DEST_o), 32'(m_gnt));
      check({tag, " model completed"}, 32'(wdata_error_completed_o), 32'(m_cmpl));
    end
    if (use_exp) begin
      check({tag, " wvalid_o"}, 32'(wvalid_o), 32'(t.e_wv));
      check({tag, " wready_o"}, 32'(wready_o), 32'(t.e_wr));
      check({tag, " grant"}, 32'(grant_FIFO_DEST_o), 32'(t.e_gnt));
      check({tag, " completed"}, 32'(wdata_error_completed_o), 32'(t.e_cmpl));
    end
    hs = t.wv & m_wr & t.wl;
    if (t.rst) begin
      q.delete();
      phase    = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (phase == 0 && sz > 0 && hs) void'(q.pop_front());
      if (t.push && sz < D && !(ft && hs)) q.push_back(idx_of(t.dest));
      case (phase)
        0:       if (t.herr && sz == 0) phase = 1;
        1:       if (t.wv && t.wl) phase = 2;
        default: phase = 0;
      endcase
    end
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    rst = 1'b1; push_DEST_i = 1'b0; DEST_i = '0; wvalid_i = 1'b0;
    wlast_i = 1'b0; wready_i = '0; handle_error_i = 1'b0;
    step(v(1,0,8'h00,0,0,8'h00,0, 8'h00,0,1,0), 0, "reset0");
    step(v(1,0,8'h00,0,0,8'h00,0, 8'h00,0,1,0), 0, "reset1");

    // Reset state and a 4-beat burst to port 2.
    tbl.push_back(v(0,0,8'h00,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,1,8'h04,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hFF,0, 8'h04,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hFF,0, 8'h04,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hFF,0, 8'h04,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h04,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hFF,0, 8'h00,0,1,0));
    // Port 3 stalls for 3 cycles mid-burst.
    tbl.push_back(v(0,1,8'h08,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hFF,0, 8'h08,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hF7,0, 8'h08,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hF7,0, 8'h08,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hF7,0, 8'h08,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h08,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h00,0,1,0));
    // Errored write with empty FIFO: sink 2 beats, pulse, back to ROUTE.
    tbl.push_back(v(0,0,8'h00,0,0,8'h00,1, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'h00,1, 8'h00,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'h00,1, 8'h00,1,1,0));
    tbl.push_back(v(0,0,8'h00,0,0,8'h00,1, 8'h00,0,1,1));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h00,0,1,0));
    foreach (tbl[i]) step(tbl[i], 1, $sformatf("basic[%0d]", i));

    // Fill to full, drop the 5th and 6th pushes (6th coincides with a pop).
    tbl.delete();
    tbl.push_back(v(0,1,8'h01,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,1,8'h80,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,1,8'h02,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,1,8'h10,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,1,8'h20,0,0,8'h00,0, 8'h00,0,0,0));
    tbl.push_back(v(0,1,8'h40,1,1,8'hFF,0, 8'h01,1,0,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h80,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h02,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h10,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h00,0,1,0));
    foreach (tbl[i]) step(tbl[i], 1, $sformatf("fill[%0d]", i));

    // handle_error with 2 queued: drain both, then sink.
    tbl.delete();
    tbl.push_back(v(0,1,8'h01,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,1,8'h02,0,0,8'h00,1, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,1, 8'h01,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,1, 8'h02,1,1,0));
    tbl.push_back(v(0,0,8'h00,0,0,8'h00,1, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'h00,1, 8'h00,1,1,0));
    tbl.push_back(v(0,0,8'h00,0,0,8'h00,1, 8'h00,0,1,1));
    tbl.push_back(v(0,0,8'h00,0,0,8'h00,0, 8'h00,0,1,0));
    foreach (tbl[i]) step(tbl[i], 1, $sformatf("errq[%0d]", i));

    // Reset mid-burst with 3 entries queued.
    tbl.delete();
    tbl.push_back(v(0,1,8'h01,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,1,8'h02,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,1,8'h04,0,0,8'h00,0, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hFF,0, 8'h01,1,1,0));
    tbl.push_back(v(1,0,8'h00,1,0,8'hFF,0, 8'h01,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,0,8'hFF,0, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h00,0,1,0));
    foreach (tbl[i]) step(tbl[i], 1, $sformatf("rstmid[%0d]", i));

    // Push into an empty FIFO together with W beats.
    tbl.delete();
`ifdef AXI_W_DEST_FALLTHROUGH_EN
    tbl.push_back(v(0,1,8'h04,1,0,8'hFF,0, 8'h04,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h04,1,1,0));
    tbl.push_back(v(0,1,8'h08,1,1,8'hFF,0, 8'h08,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h00,0,1,0));
`else
    tbl.push_back(v(0,1,8'h04,1,0,8'hFF,0, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h04,1,1,0));
    tbl.push_back(v(0,1,8'h08,1,1,8'hFF,0, 8'h00,0,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h08,1,1,0));
    tbl.push_back(v(0,0,8'h00,1,1,8'hFF,0, 8'h00,0,1,0));
`endif
    foreach (tbl[i]) step(tbl[i], 1, $sformatf("ft[%0d]", i));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rv.rst    = ($urandom_range(0, 299) == 0);
      rv.push   = ($urandom_range(0, 2) == 0);
      rv.dest   = 8'h01 << $urandom_range(0, N - 1);
      rv.wv     = $urandom_range(0, 1) == 1;
      rv.wl     = ($urandom_range(0, 2) == 0);
      rv.wr     = 8'($urandom);
      rv.herr   = ($urandom_range(0, 9) == 0);
      rv.e_wv   = '0;
      rv.e_wr   = 1'b0;
      rv.e_gnt  = 1'b0;
      rv.e_cmpl = 1'b0;
      step(rv, 0, $sformatf("rand[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
